// File: rtl/mult4_serie.sv
// Sequential 4x4 unsigned shift-and-add multiplier. A single Sum4 ripple adder
// is reused once per clock; start/busy/done handshake via Start/Ocupado/Listo.

module Sum4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Suma,
  output logic       Carry
);

  logic [4:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Suma[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Carry = c[4];

endmodule

module mult4_serie (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       Ocupado,
  output logic       Listo,
  output logic [7:0] Producto
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] m_q, m_d;
  logic [3:0] ph_q, ph_d;
  logic [3:0] q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] prod_q, prod_d;

  logic [3:0] add_b;
  logic [3:0] suma;
  logic       carry;
  logic [7:0] shift_w;

  // Multiplicand is added only when the current multiplier LSB is set.
  assign add_b = q_q[0] ? m_q : 4'b0000;

  Sum4 u_sum4 (
    .A     (ph_q),
    .B     (add_b),
    .Suma  (suma),
    .Carry (carry)
  );

  // {C,S,Q} >> 1: the adder carry lands in PH[3], so no bit is lost.
  assign shift_w = {carry, suma, q_q[3:1]};

  always_comb begin
    estado_d = estado_q;
    m_d      = m_q;
    ph_d     = ph_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (estado_q)
      IDLE: begin
        if (Start) begin
          m_d      = A;
          q_d      = B;
          ph_d     = 4'b0000;
          cnt_d    = 2'd0;
          estado_d = CALC;
        end
      end
      CALC: begin
        {ph_d, q_d} = shift_w;
        cnt_d       = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          prod_d   = shift_w;
          estado_d = FIN;
        end
      end
      FIN: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= IDLE;
      m_q      <= 4'b0000;
      ph_q     <= 4'b0000;
      q_q      <= 4'b0000;
      cnt_q    <= 2'd0;
      prod_q   <= 8'h00;
    end else begin
      estado_q <= estado_d;
      m_q      <= m_d;
      ph_q     <= ph_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  // Handshake flags come straight from the registered state.
  assign Ocupado  = (estado_q == CALC);
  assign Listo    = (estado_q == FIN);
  assign Producto = prod_q;

endmodule
